// File: rtl/shared_inc_pkg.sv
// Shared types and defaults for the time-shared incrementer scheduler.
package shared_inc_pkg;
    localparam int NCH_DEF   = 4;
    localparam int WIDTH_DEF = 8;
    localparam int CH_W_DEF  = $clog2(NCH_DEF);

    typedef logic [CH_W_DEF-1:0]  ch_idx_t;
    typedef logic [WIDTH_DEF-1:0] cnt_t;

    typedef struct packed {
        logic    valid;
        logic    kill;
        ch_idx_t ch;
    } stage_t;

    // Channel index width; never below one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sched_inc_unit.sv
// Combinational WIDTH-bit incrementer with carry-out; the shared datapath cell.
module sched_inc_unit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum,
    output logic             co
);
    assign {co, sum} = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
endmodule

// File: rtl/shared_inc_scheduler.sv
// Round-robin scheduler sharing one incrementer among NCH count channels.
// Optional feature: SHARED_INC_SATURATE_EN makes write-back saturate instead of wrap.
module shared_inc_scheduler
    import shared_inc_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NCH-1:0]       req,
    input  logic [NCH-1:0]       clr,
    output logic [NCH-1:0]       ack,
    output logic [NCH-1:0]       wrap,
    output logic [NCH*WIDTH-1:0] count_flat,
    output logic                 busy
);
    localparam int CW = ch_w(NCH);

    typedef logic [CW-1:0] idx_t;
    typedef struct packed {
        logic valid;
        logic kill;
        idx_t ch;
    } pstage_t;

    logic [NCH-1:0][WIDTH-1:0] cnt;
    logic [WIDTH-1:0]          operand;
    logic [WIDTH-1:0]          inc_sum;
    logic [WIDTH-1:0]          wb_val;
    logic                      inc_co;

    pstage_t                   s1;
    logic                      s2_vld;
    idx_t                      s2_ch;

    idx_t                      ptr;
    idx_t                      grant;
    logic                      grant_vld;
    logic                      issue;
    logic [NCH-1:0]            inflight;
    logic [NCH-1:0]            elig;
    int                        scan;

    always_comb begin
        inflight = '0;
        if (s1.valid) inflight[s1.ch] = 1'b1;
        if (s2_vld)   inflight[s2_ch] = 1'b1;
    end

    assign elig  = req & ~inflight;
    assign issue = enable & grant_vld;

    // First eligible channel at or after ptr, wrapping modulo NCH.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        scan      = 0;
        for (int k = 0; k < NCH; k++) begin
            scan = (int'(ptr) + k) % NCH;
            if (!grant_vld && elig[scan]) begin
                grant_vld = 1'b1;
                grant     = idx_t'(scan);
            end
        end
    end

    sched_inc_unit #(.WIDTH(WIDTH)) u_inc (
        .a   (operand),
        .sum (inc_sum),
        .co  (inc_co)
    );

`ifdef SHARED_INC_SATURATE_EN
    assign wb_val = inc_co ? {WIDTH{1'b1}} : inc_sum;
`else
    assign wb_val = inc_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= '0;
            s2_vld  <= 1'b0;
            s2_ch   <= '0;
            ptr     <= '0;
            operand <= '0;
            ack     <= '0;
            wrap    <= '0;
        end else begin
            // A clear landing on the grant edge makes the fetched operand stale.
            s1.valid <= issue;
            s1.kill  <= clr[grant];
            s1.ch    <= grant;
            operand  <= cnt[grant];
            if (issue) ptr <= idx_t'((int'(grant) + 1) % NCH);

            s2_vld <= s1.valid;
            s2_ch  <= s1.ch;

            ack  <= '0;
            wrap <= '0;
            if (s1.valid) begin
                ack[s1.ch]  <= 1'b1;
                wrap[s1.ch] <= inc_co & ~s1.kill & ~clr[s1.ch];
            end
        end
    end

    // Clear has priority over the write-back of the same channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr[i])
                    cnt[i] <= '0;
                else if (s1.valid && !s1.kill && s1.ch == idx_t'(i))
                    cnt[i] <= wb_val;
            end
        end
    end

    assign count_flat = cnt;
    assign busy       = s1.valid | s2_vld;
endmodule

// File: tb/tb_shared_inc_scheduler.sv
// Directed bench for shared_inc_scheduler (NCH=4, WIDTH=8): vector table plus corner sequences.
module tb_shared_inc_scheduler;
    logic        clk;
    logic        rst;
    logic        enable;
    logic [3:0]  req;
    logic [3:0]  clr;
    logic [3:0]  ack;
    logic [3:0]  wrap;
    logic [31:0] count_flat;
    logic        busy;

    int npass = 0;
    int nchk  = 0;

    typedef struct {
        logic        do_rst;
        logic        en;
        logic [3:0]  req;
        logic [3:0]  clr;
        logic [3:0]  ack;
        logic [3:0]  wrap;
        logic [31:0] cnt;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    shared_inc_scheduler #(.NCH(4), .WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .req        (req),
        .clr        (clr),
        .ack        (ack),
        .wrap       (wrap),
        .count_flat (count_flat),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic void add(input logic r, input logic e, input logic [3:0] rq,
                                input logic [3:0] cl, input logic [3:0] a,
                                input logic [3:0] w, input logic [31:0] c, input logic b);
        vec_t v;
        v.do_rst = r; v.en = e; v.req = rq; v.clr = cl;
        v.ack = a; v.wrap = w; v.cnt = c; v.busy = b;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req = '0; clr = '0; enable = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Raise req[ch], wait (bounded) for its ack, drop req in the ack cycle.
    task automatic do_op(input int ch, output logic got, output logic w, output int lat);
        got = 1'b0; w = 1'b0; lat = 0;
        req[ch] = 1'b1;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(posedge clk);
            #1;
            if (ack[ch]) begin
                got = 1'b1; w = wrap[ch]; lat = c;
            end
        end
        req[ch] = 1'b0;
    endtask

    initial begin
        int   c2[4];
        logic got;
        logic w;
        int   lat;
        logic [7:0] exp_top;

        rst = 1'b1; enable = 1'b0; req = '0; clr = '0;
        #2;
        chk("reset_count", count_flat, 32'h0);
        chk("reset_ack", {28'h0, ack}, 32'h0);
        chk("reset_wrap", {28'h0, wrap}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);

        // single request from count 0
        add(1, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 32'h00000000, 1);
        add(0, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 32'h00000001, 1);
        add(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h00000001, 0);

        // all four held for 12 cycles: ack rotates 0,1,2,3 after one fill cycle
        for (int k = 0; k < 4; k++) c2[k] = 0;
        for (int k = 0; k <= 12; k++) begin
            if (k >= 1) c2[(k - 1) % 4]++;
            add(k == 0, 1, (k < 12) ? 4'hF : 4'h0, 4'h0,
                (k == 0) ? 4'h0 : 4'(4'b0001 << ((k - 1) % 4)), 4'h0,
                {8'(c2[3]), 8'(c2[2]), 8'(c2[1]), 8'(c2[0])}, 1);
        end
        add(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 32'h03030303, 0);

        // enable low stalls issue; resume continues from stored ptr (2)
        add(1, 1, 4'hF, 4'h0, 4'b0000, 4'h0, 32'h00000000, 1);
        add(0, 1, 4'hF, 4'h0, 4'b0001, 4'h0, 32'h00000001, 1);
        add(0, 0, 4'hF, 4'h0, 4'b0010, 4'h0, 32'h00000101, 1);
        add(0, 0, 4'hF, 4'h0, 4'b0000, 4'h0, 32'h00000101, 0);
        add(0, 0, 4'hF, 4'h0, 4'b0000, 4'h0, 32'h00000101, 0);
        add(0, 0, 4'hF, 4'h0, 4'b0000, 4'h0, 32'h00000101, 0);
        add(0, 1, 4'hF, 4'h0, 4'b0000, 4'h0, 32'h00000101, 1);
        add(0, 1, 4'hF, 4'h0, 4'b0100, 4'h0, 32'h00010101, 1);
        add(0, 1, 4'h0, 4'h0, 4'b1000, 4'h0, 32'h01010101, 1);
        add(0, 1, 4'h0, 4'h0, 4'b0000, 4'h0, 32'h01010101, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_rst) apply_reset();
            enable = vecs[i].en; req = vecs[i].req; clr = vecs[i].clr;
            step();
            chk($sformatf("vec%0d_ack", i), {28'h0, ack}, {28'h0, vecs[i].ack});
            chk($sformatf("vec%0d_wrap", i), {28'h0, wrap}, {28'h0, vecs[i].wrap});
            chk($sformatf("vec%0d_count", i), count_flat, vecs[i].cnt);
            chk($sformatf("vec%0d_busy", i), {31'h0, busy}, {31'h0, vecs[i].busy});
        end

        // latency and wrap-around on channel 2
        apply_reset();
        do_op(2, got, w, lat);
        chk("op_latency", 32'(lat), 32'd2);
        step();
        for (int n = 1; n < 255; n++) begin
            do_op(2, got, w, lat);
            if (!got || w) chk($sformatf("fill_op%0d_ack_nowrap", n), {30'h0, got, w}, 32'h2);
            step();
        end
        chk("cnt2_full", {24'h0, count_flat[23:16]}, 32'hFF);
        do_op(2, got, w, lat);
`ifdef SHARED_INC_SATURATE_EN
        exp_top = 8'hFF;
`else
        exp_top = 8'h00;
`endif
        chk("wrap_ack", {31'h0, got}, 32'h1);
        chk("wrap_pulse", {31'h0, w}, 32'h1);
        chk("wrap_cnt2", {24'h0, count_flat[23:16]}, {24'h0, exp_top});
        step();

        // clear on the grant edge: op killed, still acked, no write-back
        do_op(1, got, w, lat);
        step();
        chk("pre_clrA_cnt1", {24'h0, count_flat[15:8]}, 32'h01);
        req[1] = 1'b1; clr[1] = 1'b1;
        step();
        clr[1] = 1'b0;
        chk("clrA_cnt1_cleared", {24'h0, count_flat[15:8]}, 32'h0);
        step();
        chk("clrA_ack", {28'h0, ack}, 32'h2);
        chk("clrA_wrap", {28'h0, wrap}, 32'h0);
        chk("clrA_cnt1", {24'h0, count_flat[15:8]}, 32'h0);
        req[1] = 1'b0;
        step();

        // clear on the write-back edge: clear wins, ack still pulses
        do_op(1, got, w, lat);
        step();
        chk("pre_clrB_cnt1", {24'h0, count_flat[15:8]}, 32'h01);
        req[1] = 1'b1;
        step();
        clr[1] = 1'b1;
        step();
        clr[1] = 1'b0;
        chk("clrB_ack", {28'h0, ack}, 32'h2);
        chk("clrB_wrap", {28'h0, wrap}, 32'h0);
        chk("clrB_cnt1", {24'h0, count_flat[15:8]}, 32'h0);
        req[1] = 1'b0;
        step();
        chk("clrB_idle_ack", {28'h0, ack}, 32'h0);

        // async reset with both stages occupied
        apply_reset();
        req = 4'hF;
        step();
        step();
        chk("prerst_busy", {31'h0, busy}, 32'h1);
        chk("prerst_cnt", count_flat, 32'h00000001);
        req = 4'h0;
        rst = 1'b1;
        #1;
        chk("rst_cnt", count_flat, 32'h0);
        chk("rst_ack", {28'h0, ack}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("postrst_ack", {28'h0, ack}, 32'h0);
        chk("postrst_busy", {31'h0, busy}, 32'h0);
        chk("postrst_cnt", count_flat, 32'h0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
